commit_trace_fifo: RTL and testbench
====================================

// Module: commit_trace_fifo
// PURPOSE
//   Producer side of the commit-trace interface. Captures per-cycle writeback records
//   (inst, dnpc, kill, invalid) from the WB stage and discards killed records.
//   Buffers surviving records in a small FIFO and presents them one per cycle over a
//   valid/ready port to the trace/difftest consumer.
//   Also keeps a retired-instruction count and a sticky invalid-instruction flag.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >= 2
//   INST_W  32  instruction width
//   PC_W    64  dnpc width
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   wb_valid     in   1       WB stage presents a record this cycle
//   wb_inst      in   INST_W  committed instruction word
//   wb_dnpc      in   PC_W    next PC after this instruction
//   wb_kill      in   1       record squashed; never enqueued
//   wb_invalid   in   1       instruction decoded as illegal
//   wb_ready     out  1       FIFO can accept a record this cycle
//   out_valid    out  1       head record available
//   out_inst     out  INST_W  head instruction
//   out_dnpc     out  PC_W    head dnpc
//   out_invalid  out  1       head invalid flag
//   out_ready    in   1       consumer takes head this cycle
//   commit_cnt   out  64      records dequeued since reset
//   err_invalid  out  1       sticky: an invalid record has been dequeued
// BEHAVIOUR
//   Reset (async assert, sync-released use): count=0, rd_ptr=wr_ptr=0, commit_cnt=0, err_invalid=0.
//     Outputs during reset: out_valid=0, out_inst=0, out_dnpc=0, out_invalid=0, wb_ready=1.
//     Storage array is not reset.
//   Reset mid-operation: all buffered records are lost. No partial record survives.
//   wb_ready = (count != DEPTH). Depends on registered state only, no path from out_ready.
//   push = wb_valid & wb_ready & ~wb_kill. A killed record consumes no slot and has no effect.
//   pop  = out_valid & out_ready. out_valid = (count != 0).
//   Latency: a record pushed in cycle N is visible at out_* in cycle N+1. No same-cycle bypass.
//   out_* are driven from the head entry and forced to 0 when count==0.
//   out_* hold stable while out_valid & ~out_ready (standard valid/ready rules).
//   Simultaneous push & pop: count unchanged, both pointers advance.
//   Full: wb_ready=0, so a push that cycle is impossible even if pop=1.
//     The WB stage must hold its record.
//   Empty: pop is impossible, out_ready is ignored.
//   Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//   commit_cnt += 1 on every pop, wraps modulo 2^64.
//   err_invalid set on pop of a record with invalid=1. It clears only on reset.
//   Invalid records are still enqueued and delivered; the consumer decides what to do.
// STRUCTURE
//   Package commit_trace_pkg holds:
//     - commit_rec_t packed struct {inst[INST_W], dnpc[PC_W], invalid}
//     - default DEPTH/INST_W/PC_W localparams
//   One sub-module: commit_fifo_mem, a DEPTH x commit_rec_t register array
//     (write port: wr_en/wr_addr/wr_data; async read port: rd_addr -> rd_data).
//   Pointer, count, counter and flag logic stay in this module.
// TESTING
//   1 Reset then idle: out_valid=0, wb_ready=1, commit_cnt=0, err_invalid=0, out_*=0.
//   2 Single push:
//       stimulus: inst=32'h00100073, dnpc=64'h80000004, out_ready=1.
//       response: next cycle out_valid=1 with those values; cycle after, commit_cnt=1.
//   3 Killed record:
//       stimulus: wb_valid=1, wb_kill=1.
//       response: out_valid stays 0, count unchanged, commit_cnt unchanged.
//   4 Fill with out_ready=0:
//       stimulus: 4 pushes (dnpc 0x10,0x20,0x30,0x40).
//       response: wb_ready=0 after the 4th; a 5th push is held.
//       Then out_ready=1: records drain in order 0x10..0x40 with the 5th following;
//       commit_cnt=5.
//   5 Full + simultaneous events:
//       stimulus: full FIFO, out_ready=1 and wb_valid=1 in the same cycle.
//       response: pop occurs, push is refused that cycle (wb_ready was 0),
//       accepted next cycle; pointer wrap keeps order.
//   6 Invalid + reset:
//       stimulus: push invalid=1 and pop it.
//       response: err_invalid=1 and stays set.
//       Then push 2 records, assert rst_n=0 mid-stream: out_valid=0, err_invalid=0,
//       commit_cnt=0 immediately (asynchronous).

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared types and default sizes for the commit-trace producer.
//   commit_rec_t : one buffered writeback record {inst, dnpc, invalid}
//   CT_DEPTH     : default FIFO depth (power of two, >= 2)
//   CT_INST_W    : instruction word width
//   CT_PC_W      : dnpc width
package commit_trace_pkg;

   localparam int unsigned CT_DEPTH  = 4;
   localparam int unsigned CT_INST_W = 32;
   localparam int unsigned CT_PC_W   = 64;

   typedef struct packed {
      logic [CT_INST_W-1:0] inst;
      logic [CT_PC_W-1:0]   dnpc;
      logic                 invalid;
   } commit_rec_t;

endpackage

// File: rtl/commit_fifo_mem.sv
// Register array holding commit records for commit_trace_fifo.
//   clk     : write clock
//   wr_en   : write wr_data into entry wr_addr on the rising edge
//   wr_addr : write index
//   wr_data : record to store
//   rd_addr : read index (combinational read)
//   rd_data : record at rd_addr
// The array is intentionally not reset; occupancy is tracked by the caller.
module commit_fifo_mem
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH = CT_DEPTH,
   parameter int unsigned AW    = $clog2(CT_DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  commit_rec_t   wr_data,
   input  logic [AW-1:0] rd_addr,
   output commit_rec_t   rd_data
);

   commit_rec_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/commit_trace_fifo.sv
// Producer side of the commit-trace interface. Drops killed writeback records,
// buffers the rest and hands them to the trace consumer over valid/ready.
// Also counts retired records and latches a sticky illegal-instruction flag.
//   clk, rst_n                       : clock, async active-low reset
//   wb_valid/wb_inst/wb_dnpc         : writeback record from the WB stage
//   wb_kill                          : record squashed, never buffered
//   wb_invalid                       : record decoded as illegal
//   wb_ready                         : a slot is free this cycle
//   out_valid/out_inst/out_dnpc/
//   out_invalid                      : head record (zeroed when empty)
//   out_ready                        : consumer takes the head this cycle
//   commit_cnt                       : records dequeued since reset
//   err_invalid                      : an illegal record has been dequeued
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int unsigned DEPTH = CT_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wb_valid,
   input  logic [CT_INST_W-1:0] wb_inst,
   input  logic [CT_PC_W-1:0]   wb_dnpc,
   input  logic                 wb_kill,
   input  logic                 wb_invalid,
   output logic                 wb_ready,
   output logic                 out_valid,
   output logic [CT_INST_W-1:0] out_inst,
   output logic [CT_PC_W-1:0]   out_dnpc,
   output logic                 out_invalid,
   input  logic                 out_ready,
   output logic [63:0]          commit_cnt,
   output logic                 err_invalid
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   commit_rec_t   wr_rec;
   commit_rec_t   head_rec;

   // Ready comes from occupancy only, so there is no out_ready -> wb_ready path;
   // a full FIFO refuses a push even in a cycle where it also pops.
   assign wb_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = wb_valid & wb_ready & ~wb_kill;
   assign pop       = out_valid & out_ready;

   assign wr_rec = '{inst: wb_inst, dnpc: wb_dnpc, invalid: wb_invalid};

   commit_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_rec),
      .rd_addr (rd_ptr),
      .rd_data (head_rec)
   );

   // Unwritten storage is never reset, so mask the head when nothing is buffered.
   assign out_inst    = out_valid ? head_rec.inst    : '0;
   assign out_dnpc    = out_valid ? head_rec.dnpc    : '0;
   assign out_invalid = out_valid ? head_rec.invalid : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         commit_cnt  <= '0;
         err_invalid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            commit_cnt <= commit_cnt + 64'd1;
            if (head_rec.invalid) begin
               err_invalid <= 1'b1;
            end
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_inst = '0;
   logic [63:0] wb_dnpc = '0;
   logic        wb_kill = 1'b0;
   logic        wb_invalid = 1'b0;
   logic        wb_ready;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [63:0] out_dnpc;
   logic        out_invalid;
   logic        out_ready = 1'b0;
   logic [63:0] commit_cnt;
   logic        err_invalid;

   always #5 clk = ~clk;

   commit_trace_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .wb_inst     (wb_inst),
      .wb_dnpc     (wb_dnpc),
      .wb_kill     (wb_kill),
      .wb_invalid  (wb_invalid),
      .wb_ready    (wb_ready),
      .out_valid   (out_valid),
      .out_inst    (out_inst),
      .out_dnpc    (out_dnpc),
      .out_invalid (out_invalid),
      .out_ready   (out_ready),
      .commit_cnt  (commit_cnt),
      .err_invalid (err_invalid)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] dnpc;
      logic        inv;
   } exp_rec_t;

   localparam int MODEL_DEPTH = 4;

   exp_rec_t    sb[$];
   exp_rec_t    head;
   logic [63:0] m_cnt = '0;
   logic        m_err = 1'b0;
   logic        m_valid;
   logic        m_ready;
   logic        m_push;
   logic        m_pop;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: sampled mid-cycle, updated with what the next edge will do.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_cnt = '0;
         m_err = 1'b0;
      end else begin
         m_valid = (sb.size() != 0);
         m_ready = (sb.size() != MODEL_DEPTH);
         check("wb_ready", {63'd0, wb_ready}, {63'd0, m_ready});
         check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
         check("commit_cnt", commit_cnt, m_cnt);
         check("err_invalid", {63'd0, err_invalid}, {63'd0, m_err});
         if (m_valid) begin
            head = sb[0];
            check("out_inst", {32'd0, out_inst}, {32'd0, head.inst});
            check("out_dnpc", out_dnpc, head.dnpc);
            check("out_invalid", {63'd0, out_invalid}, {63'd0, head.inv});
         end else begin
            check("out_inst_idle", {32'd0, out_inst}, 64'd0);
            check("out_dnpc_idle", out_dnpc, 64'd0);
            check("out_invalid_idle", {63'd0, out_invalid}, 64'd0);
         end
         m_push = wb_valid & m_ready & ~wb_kill;
         m_pop  = m_valid & out_ready;
         if (m_pop) begin
            void'(sb.pop_front());
            m_cnt = m_cnt + 64'd1;
            if (head.inv) m_err = 1'b1;
         end
         if (m_push) sb.push_back('{inst: wb_inst, dnpc: wb_dnpc, inv: wb_invalid});
      end
   end

   task automatic cyc(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a record and hold it until the FIFO takes it (bounded).
   task automatic push(input logic [31:0] i, input logic [63:0] d, input logic inv);
      bit acc;
      acc = 1'b0;
      wb_valid = 1'b1;
      wb_kill = 1'b0;
      wb_inst = i;
      wb_dnpc = d;
      wb_invalid = inv;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = wb_ready;
         cyc();
      end
      wb_valid = 1'b0;
      wb_invalid = 1'b0;
      if (!acc) check("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 50 && sb.size() != 0; k++) cyc();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset then idle
      cyc(2);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_wb_ready", {63'd0, wb_ready}, 64'd1);
      rst_n = 1'b1;
      cyc(3);
      check("idle_commit_cnt", commit_cnt, 64'd0);

      // 2: single push, visible next cycle, popped the cycle after
      out_ready = 1'b1;
      push(32'h0010_0073, 64'h8000_0004, 1'b0);
      check("single_valid", {63'd0, out_valid}, 64'd1);
      check("single_inst", {32'd0, out_inst}, 64'h0010_0073);
      check("single_dnpc", out_dnpc, 64'h8000_0004);
      cyc();
      check("single_cnt", commit_cnt, 64'd1);

      // 3: killed record is ignored
      wb_valid = 1'b1;
      wb_kill = 1'b1;
      wb_inst = 32'hdead_beef;
      cyc(2);
      wb_valid = 1'b0;
      wb_kill = 1'b0;
      cyc();
      check("kill_valid", {63'd0, out_valid}, 64'd0);
      check("kill_cnt", commit_cnt, 64'd1);

      // 4: fill with consumer stalled, fifth record held
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) push(32'h1000 + 32'(k), 64'(k * 16), 1'b0);
      check("full_ready", {63'd0, wb_ready}, 64'd0);
      wb_valid = 1'b1;
      wb_inst = 32'h1005;
      wb_dnpc = 64'h50;
      cyc(3);
      check("full_hold_ready", {63'd0, wb_ready}, 64'd0);
      check("full_hold_head", out_dnpc, 64'h10);
      out_ready = 1'b1;
      push(32'h1005, 64'h50, 1'b0);
      drain();
      check("fill_cnt", commit_cnt, 64'd6);

      // 5: full + simultaneous pop and push attempt across pointer wrap
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) push(32'h2000 + 32'(k), 64'h100 * 64'(k), 1'b0);
      wb_valid = 1'b1;
      wb_inst = 32'h2005;
      wb_dnpc = 64'h500;
      out_ready = 1'b1;
      cyc();
      check("simul_ready_after_pop", {63'd0, wb_ready}, 64'd1);
      check("simul_head", out_dnpc, 64'h200);
      push(32'h2005, 64'h500, 1'b0);
      drain();
      check("simul_cnt", commit_cnt, 64'd11);

      // 6: invalid record sets sticky flag; async reset clears everything
      push(32'hffff_ffff, 64'h600, 1'b1);
      drain();
      cyc(3);
      check("err_sticky", {63'd0, err_invalid}, 64'd1);
      out_ready = 1'b0;
      push(32'h3001, 64'h700, 1'b0);
      push(32'h3002, 64'h800, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check("arst_err", {63'd0, err_invalid}, 64'd0);
      check("arst_cnt", commit_cnt, 64'd0);
      check("arst_ready", {63'd0, wb_ready}, 64'd1);
      cyc(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      cyc(3);
      check("post_rst_valid", {63'd0, out_valid}, 64'd0);
      push(32'h4001, 64'h900, 1'b0);
      drain();
      check("post_rst_cnt", commit_cnt, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
